// File: rtl/ifetch_prefetch_if.sv
// Pipelined instruction-bus bundle between the fetch unit (master) and the
// instruction memory (slave); responses return in request order.
interface ifetch_prefetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              inst_cyc_out;
    logic              inst_stb_out;
    logic [ADDR_W-1:0] inst_addr_out;
    logic              inst_ack_in;
    logic [DATA_W-1:0] inst_data_in;
    logic              inst_stall_in;

    modport master (
        output inst_cyc_out,
        output inst_stb_out,
        output inst_addr_out,
        input  inst_ack_in,
        input  inst_data_in,
        input  inst_stall_in
    );

    modport slave (
        input  inst_cyc_out,
        input  inst_stb_out,
        input  inst_addr_out,
        output inst_ack_in,
        output inst_data_in,
        output inst_stall_in
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetcher: credit-limited pipelined fetch into a
// show-ahead FIFO, with redirect flush and discard of stale in-flight responses.
module ifetch_prefetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    ifetch_prefetch_if.master   bus,
    input  logic                redirect_in,
    input  logic [ADDR_W-1:0]   redirect_addr_in,
    input  logic                dec_enb_in,
    output logic                inst_valid_out,
    output logic [DATA_W-1:0]   inst_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                busy_out
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
    logic              pend_valid, pend_valid_n;
    logic [ADDR_W-1:0] pend_pc, pend_pc_n;
    logic [CW-1:0]     outstanding, outstanding_n;
    logic [CW-1:0]     discard, discard_n;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wr_ptr, rd_ptr, tag_wr, tag_rd;

    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [ADDR_W-1:0] tag_q     [DEPTH];

    logic [SW-1:0]     credit_used;
    logic              stb, accept, ack, push, pop;
    logic [ADDR_W-1:0] redirect_aligned;

    assign redirect_aligned = redirect_addr_in & ~ADDR_W'(3);

    always_comb begin
        credit_used   = {1'b0, count} + {1'b0, outstanding};
        stb           = (state != IDLE) && (credit_used < SW'(DEPTH));
        accept        = stb && !bus.inst_stall_in;
        ack           = bus.inst_ack_in && (outstanding != '0);
        push          = ack && (discard == '0) && !redirect_in;
        pop           = dec_enb_in && (count != '0) && !redirect_in;
        outstanding_n = outstanding + CW'(accept) - CW'(ack);

        if (redirect_in)
            discard_n = outstanding_n;
        else
            discard_n = discard - CW'(ack && (discard != '0)) + CW'(accept && pend_valid);

        fetch_pc_n   = fetch_pc;
        pend_valid_n = pend_valid;
        pend_pc_n    = pend_pc;
        // A stalled request must stay on the bus across a redirect; the new PC
        // waits in pend_pc until that request is accepted (and then discarded).
        if (redirect_in) begin
            if (stb && bus.inst_stall_in) begin
                pend_valid_n = 1'b1;
                pend_pc_n    = redirect_aligned;
            end else begin
                fetch_pc_n   = redirect_aligned;
                pend_valid_n = 1'b0;
            end
        end else if (accept) begin
            fetch_pc_n   = pend_valid ? pend_pc : fetch_pc + ADDR_W'(4);
            pend_valid_n = 1'b0;
        end

        if (state == IDLE)
            state_n = FETCH;
        else if ((discard_n != '0) || pend_valid_n)
            state_n = FLUSH;
        else
            state_n = FETCH;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            pend_valid  <= pend_valid_n;
            pend_pc     <= pend_pc_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            if (accept) tag_wr <= tag_wr + PW'(1);
            if (ack)    tag_rd <= tag_rd + PW'(1);
            if (redirect_in) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters above.
    always_ff @(posedge sys_clk) begin
        if (accept)
            tag_q[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_data[wr_ptr] <= bus.inst_data_in;
            fifo_pc[wr_ptr]   <= tag_q[tag_rd] + ADDR_W'(4);
        end
    end

    assign bus.inst_stb_out  = stb;
    assign bus.inst_cyc_out  = stb || (outstanding != '0);
    assign bus.inst_addr_out = fetch_pc;
    assign inst_valid_out    = (count != '0);
    assign inst_out          = inst_valid_out ? fifo_data[rd_ptr] : '0;
    assign pc_out            = inst_valid_out ? fifo_pc[rd_ptr] : '0;
    assign busy_out          = (outstanding != '0) || (discard != '0);
endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Parametrised successor of the fetch path inside mem_block. It issues sequential instruction fetches on the pipelined instruction bus and keeps several requests outstanding. Returned words are buffered in a prefetch FIFO of configurable depth. Branch/jump redirects flush the FIFO and discard stale in-flight responses. Sits between the instruction bus and reg_decode, in place of the mem_block FIFO and PC logic.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
DEPTH, 4, prefetch FIFO entries (power of 2, 2..16); also the outstanding-request credit limit
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous reset, active-high
inst_cyc_out  out  1  bus cycle active
inst_stb_out  out  1  request strobe
inst_addr_out  out  ADDR_W  request address
inst_ack_in  in  1  response valid, in request order
inst_data_in  in  DATA_W  response data
inst_stall_in  in  1  slave cannot accept request this cycle
redirect_in  in  1  flush and restart fetch at redirect_addr_in
redirect_addr_in  in  ADDR_W  new PC; bits [1:0] ignored, treated as 0
dec_enb_in  in  1  decode consumes head entry
inst_valid_out  out  1  head entry valid
inst_out  out  DATA_W  head instruction
pc_out  out  ADDR_W  head instruction address + 4 (matches reg_decode pc_in)
busy_out  out  1  outstanding requests or discards pending

Behaviour:
- Clock sys_clk. Reset is synchronous, active-high, on sys_rst. Reset has priority over all inputs.
- Reset values: cyc=0, stb=0, inst_addr_out=RESET_PC, inst_valid_out=0, inst_out=0, pc_out=0, busy_out=0. FIFO empty, outstanding=0, discard=0, fetch_pc=RESET_PC, state=IDLE.
- Reset mid-operation: all of the above apply on the next edge. Acks arriving afterwards with outstanding=0 are ignored.
- States:
  - IDLE: one cycle after reset, then FETCH.
  - FETCH: normal issue.
  - FLUSH: discard>0. Issue continues at the new PC. Return to FETCH when discard reaches 0.
- Issue: stb=1 when state!=IDLE and (fifo_count + outstanding) < DEPTH.
- Accept: a request is accepted on a cycle with stb & !stall. On accept, outstanding++ and fetch_pc += 4. Address wraps mod 2^ADDR_W.
- Stall hold: while stb & stall, inst_addr_out and stb are held unchanged.
- cyc = stb | (outstanding != 0).
- Ack handling: ack decrements outstanding.
  - If discard>0: discard-- and data is dropped.
  - Else: push {data, addr+4} into the FIFO. The request address is tracked in a DEPTH-entry tag queue.
  - inst_valid_out rises the cycle after the ack (registered write, show-ahead read).
- Pop: dec_enb_in & inst_valid_out. Same-cycle push and pop is legal at any count. The credit rule guarantees the FIFO never overflows.
- Redirect (cycle of redirect_in=1):
  - FIFO is emptied and inst_valid_out=0 from the next cycle. A pop in the same cycle is ignored.
  - discard <= outstanding after this cycle's accept/ack.
  - If a request is stalled on the bus, it stays held until accepted and is then counted into discard.
  - The next new request is at redirect_addr_in.
  - Back-to-back redirects: the latest wins; discard keeps accumulating the true in-flight count.
- busy_out = (outstanding != 0) | (discard != 0).
- Acks with outstanding=0 are ignored. Bench flags them as a protocol error.

Test Plan:
- Reset then release, no stall, ack 1 cycle after each accept -> addresses 0,4,8,C,10...; first inst_valid_out 2 cycles after first accept; pc_out=4 for the word fetched at 0.
- dec_enb_in=0 permanently, DEPTH=4 -> exactly 4 accepts, then stb=0; FIFO holds 0,4,8,C; stb reasserts the cycle after a single pop.
- inst_stall_in=1 for 5 cycles at addr 8 -> addr stays 8 and stb stays 1; one accept when stall drops; no duplicate or skipped address.
- 3 outstanding (0,4,8), redirect_in with addr 0x100 -> next 3 acks dropped; first valid entry has inst from 0x100 and pc_out=0x104.
- Redirect while addr C is stalled, plus 2 outstanding -> C is accepted first; discard=3; then 0x200 is issued; no stale data appears at inst_out.
- sys_rst pulsed with 2 outstanding and 3 FIFO entries -> next cycle all outputs at reset values; late acks ignored; restart at RESET_PC.
